// File: rtl/fft_pkg.sv
// Shared definitions for the 16-sample FFT frame path.
// Holds the frame-sequencer state encoding, default geometry and the
// width helper used to size index and counter fields.
package fft_pkg;

    localparam int unsigned N_POINT_DEF = 16;
    localparam int unsigned STAGES_DEF  = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        STAGE = 3'd2,
        OUT   = 3'd3,
        POP   = 3'd4
    } state_t;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int unsigned fft_log2(input int unsigned value);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/fft_stage_timer.sv
// Butterfly stage timer: holds each stage for STAGE_CYCLES cycles and walks
// the stage index 0..STAGES-1 while enabled.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   en                  timer runs; when low both counters sit at 0
//   stage               current stage index (registered)
//   last_stage_done_c   combinational: final cycle of the final stage
module fft_stage_timer
    import fft_pkg::*;
#(
    parameter int unsigned STAGES       = STAGES_DEF,
    parameter int unsigned STAGE_CYCLES = 2,
    localparam int unsigned STG_W       = fft_log2(STAGES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [STG_W-1:0] stage,
    output logic             last_stage_done_c
);

    localparam int unsigned CYC_W = fft_log2(STAGE_CYCLES);

    logic [CYC_W-1:0] cyc;
    logic             cyc_last_c;

    assign cyc_last_c        = (cyc == CYC_W'(STAGE_CYCLES - 1));
    assign last_stage_done_c = en && cyc_last_c && (stage == STG_W'(STAGES - 1));

    // Counters clear when idle so the next frame always starts at stage 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc   <= '0;
            stage <= '0;
        end else if (!en || last_stage_done_c) begin
            cyc   <= '0;
            stage <= '0;
        end else if (cyc_last_c) begin
            cyc   <= '0;
            stage <= stage + STG_W'(1);
        end else begin
            cyc   <= cyc + CYC_W'(1);
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame-level controller for the FFT path: load, stage through the
// butterflies, stream N_POINT results with valid/ready, then pop the buffer.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   buf_finish    buffer frame-complete pulse
//   load_en       one-cycle latch strobe for the butterfly array
//   stage_en      butterfly stage active
//   fft_stage     current stage index
//   res_valid     result word available
//   res_ready     downstream accepts the result
//   res_idx       index of the presented result
//   pop_control   one-cycle buffer pop
//   frame_done    one-cycle end-of-frame pulse
//   frame_cnt     completed frames, wrapping
//   overrun       sticky: a frame arrived while busy
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned N_POINT      = N_POINT_DEF,
    parameter int unsigned STAGES       = STAGES_DEF,
    parameter int unsigned STAGE_CYCLES = 2,
    parameter int unsigned FCNT_W       = 8,
    localparam int unsigned IDX_W       = fft_log2(N_POINT),
    localparam int unsigned STG_W       = fft_log2(STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              buf_finish,
    output logic              load_en,
    output logic              stage_en,
    output logic [STG_W-1:0]  fft_stage,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDX_W-1:0]  res_idx,
    output logic              pop_control,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              overrun
);

    state_t state;
    state_t state_next;
    logic   echo_q;
    logic   last_stage_done_c;
    logic   overrun_set_c;
    logic   load_en_d;
    logic   stage_en_d;
    logic   res_valid_d;
    logic   pop_d;

    fft_stage_timer #(
        .STAGES       (STAGES),
        .STAGE_CYCLES (STAGE_CYCLES)
    ) u_timer (
        .clk               (clk),
        .rst               (rst),
        .en                (state == STAGE),
        .stage             (fft_stage),
        .last_stage_done_c (last_stage_done_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus next-cycle output decode.
    always_comb begin
        state_next    = state;
        overrun_set_c = 1'b0;
        load_en_d     = 1'b0;
        stage_en_d    = 1'b0;
        res_valid_d   = 1'b0;
        pop_d         = 1'b0;
        case (state)
            IDLE: begin
                // The buffer echoes finish right after a pop; that echo is not a frame.
                if (buf_finish && !echo_q) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                overrun_set_c = buf_finish;
                state_next    = STAGE;
            end
            STAGE: begin
                overrun_set_c = buf_finish;
                if (last_stage_done_c) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                overrun_set_c = buf_finish;
                if (res_ready && (res_idx == IDX_W'(N_POINT - 1))) begin
                    state_next = POP;
                end
            end
            POP: begin
                overrun_set_c = buf_finish;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        load_en_d   = (state_next == LOAD);
        stage_en_d  = (state_next == STAGE);
        res_valid_d = (state_next == OUT);
        pop_d       = (state_next == POP);
    end

    // Registered outputs, result index, frame counter and error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            load_en     <= 1'b0;
            stage_en    <= 1'b0;
            res_valid   <= 1'b0;
            pop_control <= 1'b0;
            frame_done  <= 1'b0;
            echo_q      <= 1'b0;
            res_idx     <= '0;
            frame_cnt   <= '0;
            overrun     <= 1'b0;
        end else begin
            load_en     <= load_en_d;
            stage_en    <= stage_en_d;
            res_valid   <= res_valid_d;
            pop_control <= pop_d;
            frame_done  <= pop_d;
            echo_q      <= (state == POP);
            if (state == POP) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
            if (overrun_set_c) begin
                overrun <= 1'b1;
            end
            if (state == OUT) begin
                if (res_ready) begin
                    res_idx <= res_idx + IDX_W'(1);
                end
            end else begin
                res_idx <= '0;
            end
        end
    end

endmodule
